// File: rtl/clk_rst_pkg.sv
// Shared types and constants for the PLL-downstream clock-enable / reset sequencer.
package clk_rst_pkg;

   // Sequencer states; encoding is visible on state_o for debug.
   typedef enum logic [1:0] {
      S_WAIT_LOCK = 2'd0,
      S_HOLD      = 2'd1,
      S_VID       = 2'd2,
      S_RUN       = 2'd3
   } state_t;

   // Divider values at which each clock enable fires.
   localparam logic [2:0] DIV_CEN_7M   = 3'd7;
   localparam logic [2:0] DIV_CEN_7M_N = 3'd3;
   localparam logic [3:0] DIV_CEN_3M58 = 4'd15;
   localparam logic [4:0] DIV_CEN_1M79 = 5'd31;

   // Counter width for a terminal count of n, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Video is held in reset until lock has been stable and the hold time has elapsed.
   function automatic logic holds_video_reset(input state_t s);
      return (s == S_WAIT_LOCK) || (s == S_HOLD);
   endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_ff #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] stages_r;

   // Shift the asynchronous input through the synchronizer chain.
   always_ff @(posedge clk) begin
      if (rst) begin
         stages_r <= '0;
      end else begin
         stages_r <= {stages_r[SYNC_STAGES-2:0], d};
      end
   end

   assign q = stages_r[SYNC_STAGES-1];

endmodule

// File: rtl/clk_reset_sequencer.sv
// Clock-enable generator and staged reset sequencer for the 57.27 MHz system clock.
// Video leaves reset first, then CPU and audio; lock loss restarts the whole sequence.
module clk_reset_sequencer
   import clk_rst_pkg::*;
#(
   parameter int SYNC_STAGES        = 2,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int HOLD_CYCLES        = 256,
   parameter int CPU_DELAY_CYCLES   = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       reset_req,
   output logic       cen_7m,
   output logic       cen_7m_n,
   output logic       cen_3m58,
   output logic       cen_1m79,
   output logic       rst_video,
   output logic       rst_cpu,
   output logic       rst_audio,
   output logic       sys_ready,
   output logic [1:0] state_o
);

   localparam int STABLE_W = cnt_width(LOCK_STABLE_CYCLES);
   localparam int HOLD_W   = cnt_width(HOLD_CYCLES);
   localparam int DLY_W    = cnt_width(CPU_DELAY_CYCLES);

   localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [DLY_W-1:0]    DLY_LAST    = DLY_W'(CPU_DELAY_CYCLES - 1);
   localparam logic [STABLE_W-1:0] STABLE_ONE  = STABLE_W'(1);
   localparam logic [HOLD_W-1:0]   HOLD_ONE    = HOLD_W'(1);
   localparam logic [DLY_W-1:0]    DLY_ONE     = DLY_W'(1);

   logic                lock_s;
   logic                req_s;
   state_t              state_r, state_nx;
   logic [STABLE_W-1:0] stable_cnt_r, stable_cnt_nx;
   logic [HOLD_W-1:0]   hold_cnt_r, hold_cnt_nx;
   logic [DLY_W-1:0]    dly_cnt_r, dly_cnt_nx;
   logic [4:0]          div_r, div_nx;
   logic                armed_r, armed_nx;
   logic                rst_video_nx, rst_cpu_nx, sys_ready_nx;
   logic                cen_7m_nx, cen_7m_n_nx, cen_3m58_nx, cen_1m79_nx;
   logic                rst_video_r, rst_cpu_r, rst_audio_r, sys_ready_r;
   logic                cen_7m_r, cen_7m_n_r, cen_3m58_r, cen_1m79_r;

   sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lock (
      .clk (clk),
      .rst (rst),
      .d   (pll_locked),
      .q   (lock_s)
   );

   sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_req (
      .clk (clk),
      .rst (rst),
      .d   (reset_req),
      .q   (req_s)
   );

   // Next-state and counter logic; lock loss outranks user requests, which outrank counting.
   always_comb begin
      state_nx      = state_r;
      stable_cnt_nx = stable_cnt_r;
      hold_cnt_nx   = hold_cnt_r;
      dly_cnt_nx    = dly_cnt_r;
      case (state_r)
         S_WAIT_LOCK: begin
            hold_cnt_nx = '0;
            dly_cnt_nx  = '0;
            if (!lock_s) begin
               stable_cnt_nx = '0;
            end else if (stable_cnt_r == STABLE_LAST) begin
               state_nx = S_HOLD;
            end else begin
               stable_cnt_nx = stable_cnt_r + STABLE_ONE;
            end
         end
         S_HOLD: begin
            dly_cnt_nx = '0;
            if (!lock_s) begin
               state_nx      = S_WAIT_LOCK;
               stable_cnt_nx = '0;
               hold_cnt_nx   = '0;
            end else if (hold_cnt_r == HOLD_LAST) begin
               state_nx    = S_VID;
               hold_cnt_nx = '0;
            end else begin
               hold_cnt_nx = hold_cnt_r + HOLD_ONE;
            end
         end
         S_VID: begin
            hold_cnt_nx = '0;
            if (!lock_s) begin
               state_nx      = S_WAIT_LOCK;
               stable_cnt_nx = '0;
               dly_cnt_nx    = '0;
            end else if (req_s) begin
               dly_cnt_nx = '0;
            end else if (dly_cnt_r == DLY_LAST) begin
               state_nx = S_RUN;
            end else begin
               dly_cnt_nx = dly_cnt_r + DLY_ONE;
            end
         end
         S_RUN: begin
            hold_cnt_nx = '0;
            if (!lock_s) begin
               state_nx      = S_WAIT_LOCK;
               stable_cnt_nx = '0;
               dly_cnt_nx    = '0;
            end else if (req_s) begin
               state_nx   = S_VID;
               dly_cnt_nx = '0;
            end else begin
               dly_cnt_nx = dly_cnt_r;
            end
         end
         default: begin
            state_nx      = S_WAIT_LOCK;
            stable_cnt_nx = '0;
            hold_cnt_nx   = '0;
            dly_cnt_nx    = '0;
         end
      endcase
   end

   // Output and divider precompute; outputs are registered from the next state so they track state_o.
   always_comb begin
      rst_video_nx = holds_video_reset(state_nx);
      rst_cpu_nx   = (state_nx != S_RUN);
      sys_ready_nx = (state_nx == S_RUN);
      div_nx       = 5'd0;
      armed_nx     = 1'b0;
      if (rst_video_r || rst_video_nx) begin
         div_nx   = 5'd0;
         armed_nx = 1'b0;
      end else begin
         div_nx   = div_r + 5'd1;
         armed_nx = armed_r | (div_nx[2:0] == DIV_CEN_7M);
      end
      // The opposite-phase enable waits for the first cen_7m so nothing fires early after release.
      cen_7m_nx   = (div_nx[2:0] == DIV_CEN_7M);
      cen_7m_n_nx = armed_r && (div_nx[2:0] == DIV_CEN_7M_N);
      cen_3m58_nx = (div_nx[3:0] == DIV_CEN_3M58);
      cen_1m79_nx = (div_nx == DIV_CEN_1M79);
   end

   // State, counters, divider and every output flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= S_WAIT_LOCK;
         stable_cnt_r <= '0;
         hold_cnt_r   <= '0;
         dly_cnt_r    <= '0;
         div_r        <= 5'd0;
         armed_r      <= 1'b0;
         rst_video_r  <= 1'b1;
         rst_cpu_r    <= 1'b1;
         rst_audio_r  <= 1'b1;
         sys_ready_r  <= 1'b0;
         cen_7m_r     <= 1'b0;
         cen_7m_n_r   <= 1'b0;
         cen_3m58_r   <= 1'b0;
         cen_1m79_r   <= 1'b0;
      end else begin
         state_r      <= state_nx;
         stable_cnt_r <= stable_cnt_nx;
         hold_cnt_r   <= hold_cnt_nx;
         dly_cnt_r    <= dly_cnt_nx;
         div_r        <= div_nx;
         armed_r      <= armed_nx;
         rst_video_r  <= rst_video_nx;
         rst_cpu_r    <= rst_cpu_nx;
         rst_audio_r  <= rst_cpu_nx;
         sys_ready_r  <= sys_ready_nx;
         cen_7m_r     <= cen_7m_nx;
         cen_7m_n_r   <= cen_7m_n_nx;
         cen_3m58_r   <= cen_3m58_nx;
         cen_1m79_r   <= cen_1m79_nx;
      end
   end

   assign state_o   = state_r;
   assign rst_video = rst_video_r;
   assign rst_cpu   = rst_cpu_r;
   assign rst_audio = rst_audio_r;
   assign sys_ready = sys_ready_r;
   assign cen_7m    = cen_7m_r;
   assign cen_7m_n  = cen_7m_n_r;
   assign cen_3m58  = cen_3m58_r;
   assign cen_1m79  = cen_1m79_r;

endmodule

// File: tb/tb_clk_reset_sequencer.sv
// Scoreboard bench: stimulus queues expected state transitions with their cycle stamps,
// a monitor pops and checks each transition as it appears on state_o.
module tb_clk_reset_sequencer;

   localparam int SYNC = 2;
   localparam int LOCK = 1024;
   localparam int HOLD = 256;
   localparam int DLY  = 64;

   logic       clk = 1'b0;
   logic       rst, pll_locked, reset_req;
   logic       cen_7m, cen_7m_n, cen_3m58, cen_1m79;
   logic       rst_video, rst_cpu, rst_audio, sys_ready;
   logic [1:0] state_o;

   clk_reset_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .pll_locked (pll_locked),
      .reset_req  (reset_req),
      .cen_7m     (cen_7m),
      .cen_7m_n   (cen_7m_n),
      .cen_3m58   (cen_3m58),
      .cen_1m79   (cen_1m79),
      .rst_video  (rst_video),
      .rst_cpu    (rst_cpu),
      .rst_audio  (rst_audio),
      .sys_ready  (sys_ready),
      .state_o    (state_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   // Count rising edges; sampled at the falling edge it equals the number of edges so far.
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [1:0] st;
      int         cyc;
   } exp_t;

   exp_t       sb[$];
   exp_t       e;
   int         vectors = 0;
   int         miscompares = 0;
   bit         mon_en = 1'b0;
   logic [1:0] prev_st;
   int         first_cen_at = -1;
   int         ce_leak = 0;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input logic [1:0] st, input int c);
      exp_t x;
      x.st  = st;
      x.cyc = c;
      sb.push_back(x);
   endtask

   // Expected transitions for a full lock sequence whose last input change happened at cycle b.
   task automatic push_full_seq(input int b);
      push(2'd1, b + SYNC + LOCK);
      push(2'd2, b + SYNC + LOCK + HOLD);
      push(2'd3, b + SYNC + LOCK + HOLD + DLY);
   endtask

   task automatic wait_state(input logic [1:0] s, input int budget, input string name);
      int n = 0;
      while (state_o !== s && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, int'(state_o === s), 1);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_rst_video"}, int'(rst_video), 1);
      check({tag, "_rst_cpu"}, int'(rst_cpu), 1);
      check({tag, "_rst_audio"}, int'(rst_audio), 1);
      check({tag, "_sys_ready"}, int'(sys_ready), 0);
      check({tag, "_state"}, int'(state_o), 0);
      check({tag, "_cen_any"}, int'(cen_7m | cen_7m_n | cen_3m58 | cen_1m79), 0);
   endtask

   // 256-cycle window of enable checks: counts, spacing and phase relationships.
   task automatic ce_window(input string tag);
      int n7 = 0, n7n = 0, n3 = 0, n1 = 0, err = 0;
      int last7 = -1, last3 = -1, last1 = -1;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         if (cen_7m) begin
            if (last7 >= 0 && cyc - last7 != 8) err++;
            last7 = cyc;
            n7++;
         end
         if (cen_7m_n) begin
            n7n++;
            if (last7 >= 0 && cyc - last7 != 4) err++;
         end
         if (cen_3m58) begin
            n3++;
            if (!cen_7m) err++;
            if (last3 >= 0 && cyc - last3 != 16) err++;
            last3 = cyc;
         end
         if (cen_1m79) begin
            n1++;
            if (!cen_3m58) err++;
            if (last1 >= 0 && cyc - last1 != 32) err++;
            last1 = cyc;
         end
      end
      check({tag, "_n_cen_7m"}, n7, 32);
      check({tag, "_n_cen_7m_n"}, n7n, 32);
      check({tag, "_n_cen_3m58"}, n3, 16);
      check({tag, "_n_cen_1m79"}, n1, 8);
      check({tag, "_phase_err"}, err, 0);
   endtask

   // Monitor: checks enable leakage, first enable after video release and each state transition.
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (rst_video && (cen_7m || cen_7m_n || cen_3m58 || cen_1m79)) ce_leak++;
            if (first_cen_at >= 0 && (cen_7m || cen_7m_n || cen_3m58 || cen_1m79)) begin
               check("first_cen_cycle", cyc, first_cen_at);
               check("first_cen_is_7m", int'(cen_7m), 1);
               first_cen_at = -1;
            end
            if (state_o !== prev_st) begin
               if (sb.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected_transition: got state %0d from %0d expected none (cycle %0d)",
                           state_o, prev_st, cyc);
               end else begin
                  e = sb.pop_front();
                  check("state", int'(state_o), int'(e.st));
                  check("state_cycle", cyc, e.cyc);
                  check("rst_video_in_state", int'(rst_video), int'(e.st <= 2'd1));
                  check("rst_cpu_in_state", int'(rst_cpu), int'(e.st != 2'd3));
                  check("rst_audio_in_state", int'(rst_audio), int'(e.st != 2'd3));
                  check("sys_ready_in_state", int'(sys_ready), int'(e.st == 2'd3));
                  if (e.st == 2'd2 && prev_st == 2'd1) first_cen_at = cyc + 7;
               end
               prev_st = state_o;
            end
         end
      end
   end

   int b, q, d, gg, s;

   initial begin
      rst        = 1'b1;
      pll_locked = 1'b1;
      reset_req  = 1'b0;
      repeat (4) @(negedge clk);
      check_reset_vals("reset");
      prev_st = state_o;
      mon_en  = 1'b1;

      // Power-up sequence with lock present from the start.
      b   = cyc;
      rst = 1'b0;
      push_full_seq(b);
      wait_state(2'd3, 1500, "t1_reach_run");

      // Enable pattern in S_RUN.
      ce_window("t3");

      // User reset pulse in S_RUN while enables keep running.
      fork
         ce_window("t5");
         begin
            repeat (20) @(negedge clk);
            q         = cyc;
            reset_req = 1'b1;
            push(2'd2, q + SYNC + 1);
            repeat (10) @(negedge clk);
            reset_req = 1'b0;
            push(2'd3, q + 10 + SYNC + DLY);
         end
      join
      wait_state(2'd3, 200, "t5_reach_run");

      // Lock loss in S_RUN, then restore with a one-cycle glitch during stabilisation.
      @(negedge clk);
      d          = cyc;
      pll_locked = 1'b0;
      push(2'd0, d + SYNC + 1);
      repeat (SYNC + 1) @(negedge clk);
      check_reset_vals("t4_lock_loss");
      repeat (7) @(negedge clk);
      pll_locked = 1'b1;
      repeat (500) @(negedge clk);
      gg         = cyc;
      pll_locked = 1'b0;
      @(negedge clk);
      pll_locked = 1'b1;
      push_full_seq(gg + 1);
      wait_state(2'd3, 1500, "t2_reach_run");

      // Synchronous reset in the middle of S_VID.
      @(negedge clk);
      q         = cyc;
      reset_req = 1'b1;
      push(2'd2, q + SYNC + 1);
      wait_state(2'd2, 20, "t6_reach_vid");
      repeat (5) @(negedge clk);
      s         = cyc;
      rst       = 1'b1;
      reset_req = 1'b0;
      push(2'd0, s + 1);
      @(negedge clk);
      check_reset_vals("t6_rst");
      repeat (3) @(negedge clk);
      b   = cyc;
      rst = 1'b0;
      push_full_seq(b);
      wait_state(2'd3, 1500, "t6_reach_run");

      repeat (5) @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);
      check("cen_during_video_reset", ce_leak, 0);
      check("first_cen_resolved", first_cen_at, -1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
